down_counter_tc: RTL and testbench

//   Loadable synchronous down counter with terminal-count pulse.

---
 rtl/down_counter_tc.sv | 105 ++++++++++
 tb/tb_down_counter_tc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/down_counter_tc.sv
// ---------------------------------------------------------------------------
// down_counter_tc
//   Loadable synchronous down counter with a registered terminal-count pulse.
//   A nonzero load_value starts a countdown. Each enabled cycle decrements the
//   count, and reaching zero raises tc_pulse for one cycle. Loading zero
//   leaves the counter idle. The counter serves as a programmable delay or
//   timeout source.
//
//   Optional feature macro: AUTO_RELOAD_EN
//     undefined : one-shot. On expiry the count goes to 0 and the FSM
//                 returns to IDLE.
//     defined   : periodic. On expiry the count reloads from the last loaded
//                 value and the FSM stays in RUN.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous reset, active low
//   load        in   1      load load_value this cycle (wins over enable)
//   load_value  in   WIDTH  start value
//   enable      in   1      decrement permission while running
//   count_out   out  WIDTH  current count (registered)
//   busy        out  1      high while in RUN
//   zero        out  1      high when count_out == 0
//   tc_pulse    out  1      one-cycle expiry pulse (registered)
// ---------------------------------------------------------------------------
module down_counter_tc #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             zero,
  output logic             tc_pulse
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ZERO = '0;

  state_t           r_state, r_state_next;
  logic [WIDTH-1:0] r_count, r_count_next;
  logic [WIDTH-1:0] r_reload, r_reload_next;
  logic             r_tc, r_tc_next;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= W_ZERO;
      r_reload <= W_ZERO;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= r_state_next;
      r_count  <= r_count_next;
      r_reload <= r_reload_next;
      r_tc     <= r_tc_next;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    r_state_next  = r_state;
    r_count_next  = r_count;
    r_reload_next = r_reload;
    r_tc_next     = 1'b0;

    if (load) begin
      // Load wins over a coinciding expiry, so no pulse is raised here.
      r_count_next  = load_value;
      r_reload_next = load_value;
      r_state_next  = (load_value != W_ZERO) ? RUN : IDLE;
    end else if (r_state == RUN && enable) begin
      if (r_count > W_ONE) begin
        r_count_next = r_count - W_ONE;
      end else if (r_count == W_ONE) begin
        r_tc_next = 1'b1;
`ifdef AUTO_RELOAD_EN
        r_count_next = r_reload;
        r_state_next = RUN;
`else
        r_count_next = W_ZERO;
        r_state_next = IDLE;
`endif
      end else begin
        // A zero count in RUN cannot normally occur. Park in IDLE rather
        // than wrap below zero.
        r_state_next = IDLE;
      end
    end
  end

  assign count_out = r_count;
  assign busy      = (r_state == RUN);
  assign zero      = (r_count == W_ZERO);
  assign tc_pulse  = r_tc;

endmodule

// File: tb/tb_down_counter_tc.sv
// ---------------------------------------------------------------------------
// tb_down_counter_tc
//   Scoreboard bench for down_counter_tc (WIDTH=4). The stimulus process
//   drives one cycle at a time. It advances a behavioural model and queues
//   the outputs expected after the next rising edge. A separate monitor pops
//   one entry per edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_down_counter_tc;

  localparam int W = 4;

  logic         clk = 1'b1;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         enable;
  logic [W-1:0] count_out;
  logic         busy;
  logic         zero;
  logic         tc_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         bsy;
    logic         zer;
    logic         tc;
  } exp_t;

  exp_t sb_q[$];

  // Behavioural model: a number that counts down, a running flag, and the
  // last value loaded.
  int m_count;
  bit m_run;
  int m_reload;

  down_counter_tc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .count_out  (count_out),
    .busy       (busy),
    .zero       (zero),
    .tc_pulse   (tc_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out(input bit tc);
    exp_t e;
    e.cnt = m_count[W-1:0];
    e.bsy = m_run;
    e.zer = (m_count == 0);
    e.tc  = tc;
    return e;
  endfunction

  // Drive one cycle, advance the model, and queue the expected response.
  task automatic cycle(input bit ld, input int lv, input bit en);
    bit tc;
    @(negedge clk);
    load       = ld;
    load_value = lv[W-1:0];
    enable     = en;
    tc = 1'b0;
    if (ld) begin
      m_count  = lv;
      m_reload = lv;
      m_run    = (lv != 0);
    end else if (m_run && en) begin
      if (m_count == 1) begin
        tc = 1'b1;
`ifdef AUTO_RELOAD_EN
        m_count = m_reload;
`else
        m_count = 0;
        m_run   = 1'b0;
`endif
      end else begin
        m_count = m_count - 1;
      end
    end
    sb_q.push_back(model_out(tc));
    $display("txn load=%0b lv=%0d en=%0b -> exp cnt=%0d busy=%0b tc=%0b",
             ld, lv, en, m_count, m_run, tc);
  endtask

  // Monitor: one registered response per rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("count_out", int'(count_out), int'(e.cnt));
      chk("busy",      int'(busy),      int'(e.bsy));
      chk("zero",      int'(zero),      int'(e.zer));
      chk("tc_pulse",  int'(tc_pulse),  int'(e.tc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0;
    m_count = 0; m_run = 1'b0; m_reload = 0;

    // Reset state while reset is held low.
    #12;
    chk("rst_count", int'(count_out), 0);
    chk("rst_zero",  int'(zero),      1);
    chk("rst_busy",  int'(busy),      0);
    chk("rst_tc",    int'(tc_pulse),  0);
    #3 reset = 1'b1;

    // Load 3 and keep enable high: expiry on the third enabled edge.
    cycle(1, 3, 0);
    repeat (5) cycle(0, 0, 1);

    // Load 5 and toggle enable: the count holds on the disabled cycles.
    cycle(1, 5, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, (i % 2) == 0);

    // A load on the expiry edge wins over the expiry.
    cycle(1, 2, 0);
    cycle(0, 0, 1);
    cycle(1, 9, 1);
    cycle(0, 0, 1);

    // Loading 0 leaves the counter idle.
    cycle(1, 0, 1);
    repeat (3) cycle(0, 0, 1);

    // Periodic or one-shot behaviour over a longer run.
    cycle(1, 2, 0);
    repeat (7) cycle(0, 0, 1);

    // Pull reset mid-count at value 6 of 12: the clear must not wait for a clock.
    cycle(1, 12, 0);
    repeat (6) cycle(0, 0, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_count", int'(count_out), 0);
    chk("async_zero",  int'(zero),      1);
    chk("async_busy",  int'(busy),      0);
    chk("async_tc",    int'(tc_pulse),  0);
    m_count = 0; m_run = 1'b0; m_reload = 0;
    @(negedge clk);
    load = 1'b0; enable = 1'b1;
    reset = 1'b1;
    repeat (2) cycle(0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      bit ld;
      ld = ($urandom_range(0, 7) == 0);
      cycle(ld, $urandom_range(0, 15), $urandom_range(0, 3) != 0);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
